// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] lsb);
        return (lsb & ALIGN_MASK) != 3'b000;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin winner selection
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // ptr only matters on a tie: 0 favours requester 0, 1 favours requester 1
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of a single-port DataMemory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_writeData,
    output logic                mem_MemWrite,
    output logic                mem_MemRead,
    input  logic [DATA_W-1:0]   mem_readData
);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                idx_q, idx_d;
    logic                mis_q, mis_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]          win;
    logic                win_idx;
    logic [1:0]          gnt_c;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_mis;

    rr_arbiter2 u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (win)
    );

    assign win_idx = win[1];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        mis_d       = mis_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        rvalid_d    = 2'b00;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        gnt_c       = 2'b00;
        sel_addr    = win_idx ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
        sel_wdata   = win_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        sel_we      = win_idx ? we[1] : we[0];
        sel_mis     = is_misaligned(sel_addr[2:0]);
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_c       = win;
                    state_d     = ISSUE;
                    ptr_d       = ~win_idx;
                    idx_d       = win_idx;
                    mis_d       = sel_mis;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    // a misaligned access never reaches the memory strobes
                    mem_wr_d    = sel_we & ~sel_mis;
                    mem_rd_d    = ~sel_we & ~sel_mis;
                end
            end
            ISSUE: begin
                state_d  = DONE;
                rvalid_d = idx_q ? 2'b10 : 2'b01;
                err_d    = mis_q;
                rdata_d  = mem_rd_q ? mem_readData : '0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            idx_q       <= 1'b0;
            mis_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rvalid_q    <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            mis_q       <= mis_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // gnt is the only combinational output, so it alone needs reset gating
    assign gnt           = reset ? 2'b00 : gnt_c;
    assign rvalid        = rvalid_q;
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem_address   = mem_addr_q;
    assign mem_writeData = mem_wdata_q;
    assign mem_MemWrite  = mem_wr_q;
    assign mem_MemRead   = mem_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [127:0]  addr;
    logic [127:0]  wdata;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [63:0]   rdata;
    logic          err;
    logic [63:0]   mem_address;
    logic [63:0]   mem_writeData;
    logic          mem_MemWrite;
    logic          mem_MemRead;
    logic [63:0]   mem_readData;

    logic          mem_init;
    logic [63:0]   env_mem [0:15];
    logic [63:0]   ref_mem [0:15];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          v;
        bit          idx;
        bit          we;
        bit          mis;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rexp;
    } txn_t;

    dmem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .err           (err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_readData  (mem_readData)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] init_val(input int i);
        return 64'h1234_5678_9ABC_DEF0 ^ (64'(i) * 64'h0F1E_2D3C_4B5A_6978);
    endfunction

    // DataMemory stand-in: 16 doublewords, combinational read
    assign mem_readData = mem_MemRead ? env_mem[mem_address[6:3]] : 64'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        end else if (mem_MemWrite) begin
            env_mem[mem_address[6:3]] <= mem_writeData;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = 2'b00;
        tick;
        tick;
        reset = 1'b0;
    endtask

    logic [1:0] gseq [0:8];
    bit   [1:0] pend;
    bit   [1:0] p_we;
    logic [63:0] p_addr [0:1];
    logic [63:0] p_wdata [0:1];
    logic [63:0] a;
    logic [63:0] hold_rdata;
    logic [1:0]  exp_g;
    txn_t iss, dn, newg;
    bit   rr_ptr;
    bit   w;
    int   since;

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        req      = 2'b11;
        we       = 2'b00;
        addr     = '0;
        wdata    = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        tick;
        tick;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_memrd", 64'(mem_MemRead), 64'h0);
        chk("rst_memwr", 64'(mem_MemWrite), 64'h0);
        chk("rst_addr", mem_address, 64'h0);
        mem_init = 1'b0;
        req      = 2'b00;
        reset    = 1'b0;
        tick;

        // read of address 0 by requester 0
        req = 2'b01; we = 2'b00; addr = '0;
        #1 chk("rd0_gnt", 64'(gnt), 64'h1);
        tick; req = 2'b00;
        chk("rd0_memrd", 64'(mem_MemRead), 64'h1);
        chk("rd0_memwr", 64'(mem_MemWrite), 64'h0);
        tick;
        chk("rd0_rvalid", 64'(rvalid), 64'h1);
        chk("rd0_rdata", rdata, ref_mem[0]);
        chk("rd0_err", 64'(err), 64'h0);
        tick;

        // write then read back address 8
        req = 2'b01; we = 2'b01; addr = 128'h8; wdata = 128'hDEADBEEFDEADBEEF;
        #1 chk("wr8_gnt", 64'(gnt), 64'h1);
        tick; req = 2'b00;
        chk("wr8_memwr", 64'(mem_MemWrite), 64'h1);
        chk("wr8_memrd", 64'(mem_MemRead), 64'h0);
        chk("wr8_addr", mem_address, 64'h8);
        chk("wr8_wdata", mem_writeData, 64'hDEADBEEFDEADBEEF);
        ref_mem[1] = 64'hDEADBEEFDEADBEEF;
        tick;
        chk("wr8_rvalid", 64'(rvalid), 64'h1);
        chk("wr8_rdata", rdata, 64'h0);
        tick;
        req = 2'b01; we = 2'b00;
        #1 chk("rd8_gnt", 64'(gnt), 64'h1);
        tick; req = 2'b00;
        tick;
        chk("rd8_rvalid", 64'(rvalid), 64'h1);
        chk("rd8_rdata", rdata, 64'hDEADBEEFDEADBEEF);
        chk("rd8_err", 64'(err), 64'h0);
        tick;

        // misaligned read by requester 1
        req = 2'b10; we = 2'b00; addr = {64'h14, 64'h0};
        #1 chk("mis_gnt", 64'(gnt), 64'h2);
        tick; req = 2'b00;
        chk("mis_memrd", 64'(mem_MemRead), 64'h0);
        chk("mis_memwr", 64'(mem_MemWrite), 64'h0);
        tick;
        chk("mis_rvalid", 64'(rvalid), 64'h2);
        chk("mis_err", 64'(err), 64'h1);
        chk("mis_rdata", rdata, 64'h0);
        tick;
        chk("mis_rvalid_off", 64'(rvalid), 64'h0);
        chk("mis_err_off", 64'(err), 64'h0);

        // both requesting continuously alternates from requester 0
        do_reset;
        gseq[0] = 2'b01; gseq[1] = 2'b00; gseq[2] = 2'b00;
        gseq[3] = 2'b10; gseq[4] = 2'b00; gseq[5] = 2'b00;
        gseq[6] = 2'b01; gseq[7] = 2'b00; gseq[8] = 2'b00;
        req = 2'b11; we = 2'b00; addr = '0;
        for (int k = 0; k < 9; k++) begin
            #1 chk($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(gseq[k]));
            tick;
        end
        req = 2'b00;
        tick; tick; tick;

        // reset in the middle of a write to 16 cancels it
        do_reset;
        req = 2'b01; we = 2'b01; addr = 128'h10; wdata = 128'h1111_2222_3333_4444;
        #1 chk("ab_gnt", 64'(gnt), 64'h1);
        tick; req = 2'b00;
        chk("ab_memwr", 64'(mem_MemWrite), 64'h1);
        reset = 1'b1;
        #1 chk("ab_memwr_drop", 64'(mem_MemWrite), 64'h0);
        chk("ab_addr_drop", mem_address, 64'h0);
        tick;
        chk("ab_rvalid0", 64'(rvalid), 64'h0);
        tick;
        reset = 1'b0;
        chk("ab_rvalid1", 64'(rvalid), 64'h0);
        req = 2'b01; we = 2'b00;
        #1 chk("ab_rd_gnt", 64'(gnt), 64'h1);
        tick; req = 2'b00;
        tick;
        chk("ab_rd_rvalid", 64'(rvalid), 64'h1);
        chk("ab_rd_rdata", rdata, ref_mem[2]);
        tick;

        // randomized traffic against a transaction-level model
        do_reset;
        rr_ptr = 1'b0;
        since = 3;
        pend = 2'b00;
        p_we = 2'b00;
        iss.v = 1'b0; dn.v = 1'b0; newg.v = 1'b0;
        hold_rdata = 64'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            since++;
            dn = iss;
            iss = newg;
            newg.v = 1'b0;
            chk("r_memrd", 64'(mem_MemRead), 64'(iss.v && !iss.we && !iss.mis));
            chk("r_memwr", 64'(mem_MemWrite), 64'(iss.v && iss.we && !iss.mis));
            chk("r_addr", mem_address, iss.v ? iss.addr : 64'h0);
            chk("r_wdata", mem_writeData, iss.v ? iss.wdata : 64'h0);
            chk("r_rvalid", 64'(rvalid), dn.v ? (dn.idx ? 64'h2 : 64'h1) : 64'h0);
            chk("r_err", 64'(err), 64'(dn.v && dn.mis));
            if (dn.v) hold_rdata = dn.rexp;
            chk("r_rdata", rdata, hold_rdata);

            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    p_we[i] = 1'($urandom_range(1, 0));
                    a = {57'h0, 4'($urandom_range(15, 0)), 3'b000};
                    if ($urandom_range(3, 0) == 0) a[2:0] = 3'($urandom_range(7, 1));
                    p_addr[i] = a;
                    p_wdata[i] = {$urandom, $urandom};
                end
            end
            req   = pend;
            we    = p_we;
            addr  = {p_addr[1], p_addr[0]};
            wdata = {p_wdata[1], p_wdata[0]};
            #1;
            exp_g = 2'b00;
            if (since >= 3 && pend != 2'b00) begin
                w = (pend == 2'b11) ? rr_ptr : pend[1];
                exp_g = w ? 2'b10 : 2'b01;
            end
            chk("r_gnt", 64'(gnt), 64'(exp_g));
            if (exp_g != 2'b00) begin
                newg.v     = 1'b1;
                newg.idx   = w;
                newg.we    = p_we[w];
                newg.addr  = p_addr[w];
                newg.wdata = p_wdata[w];
                newg.mis   = (p_addr[w][2:0] != 3'b000);
                newg.rexp  = (!newg.we && !newg.mis) ? ref_mem[p_addr[w][6:3]] : 64'h0;
                if (newg.we && !newg.mis) ref_mem[p_addr[w][6:3]] = p_wdata[w];
                rr_ptr  = !w;
                pend[w] = 1'b0;
                since   = 0;
            end
            tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 2 bits: per-requester access request (index 0 = requester 0).
REQ-006 SHALL have port we, input, 2 bits: per-requester write (1) or read (0).
REQ-007 SHALL have port addr, input, 2*ADDR_W bits: packed per-requester byte address; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wdata, input, 2*DATA_W bits: packed per-requester write data, same packing as addr.
REQ-009 SHALL have port gnt, output, 2 bits: one-hot acceptance of a request.
REQ-010 SHALL have port rvalid, output, 2 bits: one-hot completion pulse.
REQ-011 SHALL have port rdata, output, DATA_W bits: read data, valid with rvalid.
REQ-012 SHALL have port err, output, 1 bit: misaligned-access flag, valid with rvalid.
REQ-013 SHALL have port mem_address, output, ADDR_W bits: DataMemory address.
REQ-014 SHALL have port mem_writeData, output, DATA_W bits: DataMemory write data.
REQ-015 SHALL have port mem_MemWrite, output, 1 bit: DataMemory write enable.
REQ-016 SHALL have port mem_MemRead, output, 1 bit: DataMemory read enable.
REQ-017 SHALL have port mem_readData, input, DATA_W bits: DataMemory read data (combinational from mem_address while mem_MemRead=1).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DONE; transitions: IDLE->ISSUE when |req, ISSUE->DONE unconditionally, DONE->IDLE unconditionally.
REQ-019 In IDLE with |req, SHALL assert gnt[i] combinationally in that cycle for the winner and capture its we/addr/wdata and index at the rising edge.
REQ-020 Winner SHALL be: the sole requester if one; if both, the requester indicated by the round-robin pointer.
REQ-021 The pointer SHALL move to the non-winner after every grant.
REQ-022 gnt SHALL be 0 in ISSUE and DONE; requests arriving then wait; req dropped before gnt causes no access.
REQ-023 In ISSUE, SHALL drive mem_address/mem_writeData from the captured fields and assert exactly one of mem_MemWrite (we=1) or mem_MemRead (we=0) for one cycle; otherwise all mem_* outputs SHALL be 0.
REQ-024 Misaligned access (captured addr[2:0] != 0) SHALL NOT assert mem_MemRead or mem_MemWrite in ISSUE and SHALL set err=1 in DONE.
REQ-025 At the end of ISSUE a read SHALL register mem_readData into rdata; a write or misaligned access SHALL register rdata=0.
REQ-026 In DONE, rvalid[captured index] SHALL be 1 for exactly one cycle; rvalid=0 and err=0 otherwise.
REQ-027 Latency SHALL be: gnt at cycle T, memory strobe at T+1, rvalid at T+2, next gnt no earlier than T+3.
REQ-028 rdata SHALL hold its value until the next DONE.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, pointer=0 (requester 0 preferred), gnt=0, rvalid=0, err=0, rdata=0, and all mem_* outputs 0.
REQ-030 A reset asserted in ISSUE or DONE SHALL abort the access with no rvalid; a write aborted in ISSUE SHALL drop the strobe asynchronously.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the state enumeration, ADDR_W/DATA_W defaults, and the alignment mask constant (3'b111).
REQ-032 The 2-way round-robin selection (req, pointer -> one-hot winner) SHALL be a sub-module rr_arbiter2.

Verification
REQ-033 Reset, then req=2'b01, we=0, addr0=0 -> gnt=01 at T, mem_MemRead=1 at T+1, rvalid=01 with rdata=mem contents of address 0 at T+2.
REQ-034 Write requester 0 addr 8 data DEADBEEFDEADBEEF, then read addr 8 -> mem_MemWrite pulse at T+1, read rvalid=01 returns DEADBEEFDEADBEEF, err=0.
REQ-035 req=2'b11 held for three grants after reset -> gnt sequence 01,10,01 with gnts 3 cycles apart.
REQ-036 Requester 1 reads addr 0x14 -> no mem strobe, rvalid=10, err=1, rdata=0.
REQ-037 Reset asserted during ISSUE of a write to addr 16 -> mem_MemWrite drops at once, no rvalid, later read of 16 returns pre-write value.
